// File: rtl/shift_out_reg.sv
// Parallel-in / serial-out unload register: accepts a word over a valid/ready
// handshake and drains it one bit per shift strobe, MSB- or LSB-first.
module shift_out_reg #(
  parameter int WIDTH     = 16,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     shift_en,
  input  logic                     abort,
  output logic                     ser_out,
  output logic                     ser_valid,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_count;
  logic             r_done;

  logic             w_last;
  logic             w_load;
  logic [WIDTH-1:0] w_shifted;

  // Last bit is consumed this cycle; this is also the back-to-back reload slot.
  assign w_last    = (r_state == SHIFT) && shift_en && (r_count == '0);
  assign in_ready  = (r_state == IDLE) || w_last;
  assign w_load    = in_valid && in_ready;
  assign w_shifted = LSB_FIRST ? {1'b0, r_shreg[WIDTH-1:1]}
                               : {r_shreg[WIDTH-2:0], 1'b0};

  // NOTE: all state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else if (abort) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_state <= SHIFT;
        r_shreg <= in_data;
        r_count <= LAST_IDX;
      end else if (w_last) begin
        // The final shift leaves the register all-zero, so ser_out idles low.
        r_state <= IDLE;
        r_shreg <= w_shifted;
        r_count <= '0;
      end else if ((r_state == SHIFT) && shift_en) begin
        r_shreg <= w_shifted;
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign ser_out   = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];
  assign ser_valid = (r_state == SHIFT);
  assign bit_idx   = r_count;
  assign done      = r_done;

endmodule

// File: tb/tb_shift_out_reg.sv
// Directed bench for shift_out_reg: a 16-bit MSB-first instance and an
// 8-bit LSB-first instance, checked at the falling edge.
module tb_shift_out_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 16-bit MSB-first instance
  logic        a_rstn, a_in_valid, a_in_ready, a_shift_en, a_abort;
  logic        a_ser_out, a_ser_valid, a_done;
  logic [15:0] a_in_data;
  logic [3:0]  a_bit_idx;

  // 8-bit LSB-first instance
  logic        b_rstn, b_in_valid, b_in_ready, b_shift_en, b_abort;
  logic        b_ser_out, b_ser_valid, b_done;
  logic [7:0]  b_in_data;
  logic [2:0]  b_bit_idx;

  shift_out_reg #(.WIDTH(16), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rstn(a_rstn), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .shift_en(a_shift_en), .abort(a_abort),
    .ser_out(a_ser_out), .ser_valid(a_ser_valid), .bit_idx(a_bit_idx),
    .done(a_done)
  );

  shift_out_reg #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rstn(b_rstn), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .shift_en(b_shift_en), .abort(b_abort),
    .ser_out(b_ser_out), .ser_valid(b_ser_valid), .bit_idx(b_bit_idx),
    .done(b_done)
  );

  task automatic test_reset();
    a_rstn = 1'b0; a_in_valid = 1'b0; a_shift_en = 1'b0; a_abort = 1'b0; a_in_data = '0;
    b_rstn = 1'b0; b_in_valid = 1'b0; b_shift_en = 1'b0; b_abort = 1'b0; b_in_data = '0;
    repeat (3) @(negedge clk);
    a_rstn = 1'b1; b_rstn = 1'b1;
    @(negedge clk);
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
    total++; if (a_ser_valid !== 1'b0) begin bad++; $display("FAIL reset_ser_valid got=%b exp=0", a_ser_valid); end
    total++; if (a_ser_out !== 1'b0) begin bad++; $display("FAIL reset_ser_out got=%b exp=0", a_ser_out); end
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", a_done); end
    total++; if (a_bit_idx !== 4'd0) begin bad++; $display("FAIL reset_bit_idx got=%0d exp=0", a_bit_idx); end
    total++; if (b_in_ready !== 1'b1 || b_ser_valid !== 1'b0) begin
      bad++; $display("FAIL reset_lsb_inst got ready=%b valid=%b exp ready=1 valid=0", b_in_ready, b_ser_valid);
    end
  endtask

  // Drains a word already in flight on the MSB instance, starting at view `from`.
  task automatic drain_msb(input logic [15:0] w, input int from, input string tag);
    for (int k = from; k < 16; k++) begin
      total++; if (a_ser_out !== w[15-k] || a_bit_idx !== 4'(15-k) || a_ser_valid !== 1'b1) begin
        bad++; $display("FAIL %s_bit%0d got out=%b idx=%0d valid=%b exp out=%b idx=%0d valid=1",
                        tag, k, a_ser_out, a_bit_idx, a_ser_valid, w[15-k], 15-k);
      end
      total++; if (a_in_ready !== (k == 15)) begin
        bad++; $display("FAIL %s_ready%0d got=%b exp=%b", tag, k, a_in_ready, (k == 15));
      end
      if (k > 0) begin
        total++; if (a_done !== 1'b0) begin bad++; $display("FAIL %s_early_done%0d got=%b exp=0", tag, k, a_done); end
      end
      a_shift_en = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_msb_drain();
    a_in_data = 16'hA5C3; a_in_valid = 1'b1; a_shift_en = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL msb_done_at_load got=%b exp=0", a_done); end
    drain_msb(16'hA5C3, 0, "msb");
    total++; if (a_done !== 1'b1 || a_ser_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      bad++; $display("FAIL msb_done got done=%b valid=%b ready=%b exp 1 0 1", a_done, a_ser_valid, a_in_ready);
    end
    a_shift_en = 1'b0;
    @(negedge clk);
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL msb_done_width got=%b exp=0", a_done); end
  endtask

  task automatic test_stall();
    a_in_data = 16'h8001; a_in_valid = 1'b1; a_shift_en = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int s = 0; s < 5; s++) begin
      total++; if (a_ser_out !== 1'b1 || a_bit_idx !== 4'd15 || a_ser_valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold%0d got out=%b idx=%0d valid=%b exp out=1 idx=15 valid=1",
                        s, a_ser_out, a_bit_idx, a_ser_valid);
      end
      @(negedge clk);
    end
    drain_msb(16'h8001, 0, "stall");
    total++; if (a_done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b exp=1", a_done); end
    a_shift_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] w = 16'hFFFF;
    a_in_data = w; a_in_valid = 1'b1; a_shift_en = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      total++; if (a_ser_out !== 1'b1) begin bad++; $display("FAIL b2b_first%0d got=%b exp=1", k, a_ser_out); end
      if (k == 15) begin
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", a_in_ready); end
        a_in_valid = 1'b1; a_in_data = 16'h00FF;
      end
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    total++; if (a_ser_valid !== 1'b1 || a_bit_idx !== 4'd15 || a_ser_out !== 1'b0) begin
      bad++; $display("FAIL b2b_reload got valid=%b idx=%0d out=%b exp valid=1 idx=15 out=0",
                      a_ser_valid, a_bit_idx, a_ser_out);
    end
    total++; if (a_done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1", a_done); end
    drain_msb(16'h00FF, 0, "b2b");
    total++; if (a_done !== 1'b1) begin bad++; $display("FAIL b2b_done2 got=%b exp=1", a_done); end
    a_shift_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic [15:0] w = 16'h1234;
    a_in_data = w; a_in_valid = 1'b1; a_shift_en = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++; if (a_ser_out !== w[15-k] || a_bit_idx !== 4'(15-k)) begin
        bad++; $display("FAIL abort_pre%0d got out=%b idx=%0d exp out=%b idx=%0d",
                        k, a_ser_out, a_bit_idx, w[15-k], 15-k);
      end
      if (k == 1) begin
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL ignored_ready got=%b exp=0", a_in_ready); end
        a_in_valid = 1'b1; a_in_data = 16'hFFFF;
      end else begin
        a_in_valid = 1'b0;
      end
      @(negedge clk);
    end
    // Word must be unaffected by the load offered while in_ready was low.
    total++; if (a_ser_out !== w[11] || a_bit_idx !== 4'd11) begin
      bad++; $display("FAIL ignored_load got out=%b idx=%0d exp out=%b idx=11", a_ser_out, a_bit_idx, w[11]);
    end
    a_abort = 1'b1; a_in_valid = 1'b1; a_in_data = 16'hFFFF;
    @(negedge clk);
    a_abort = 1'b0; a_in_valid = 1'b0; a_shift_en = 1'b0;
    total++; if (a_ser_valid !== 1'b0 || a_in_ready !== 1'b1 || a_done !== 1'b0) begin
      bad++; $display("FAIL abort_state got valid=%b ready=%b done=%b exp 0 1 0", a_ser_valid, a_in_ready, a_done);
    end
    total++; if (a_ser_out !== 1'b0 || a_bit_idx !== 4'd0) begin
      bad++; $display("FAIL abort_clear got out=%b idx=%0d exp out=0 idx=0", a_ser_out, a_bit_idx);
    end
    @(negedge clk);
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b exp=0", a_done); end
  endtask

  task automatic test_lsb_first();
    b_in_data = 8'h01; b_in_valid = 1'b1; b_shift_en = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++; if (b_ser_out !== (k == 0) || b_bit_idx !== 3'(7-k) || b_done !== 1'b0) begin
        bad++; $display("FAIL lsb_bit%0d got out=%b idx=%0d done=%b exp out=%b idx=%0d done=0",
                        k, b_ser_out, b_bit_idx, b_done, (k == 0), 7-k);
      end
      @(negedge clk);
    end
    total++; if (b_done !== 1'b1 || b_ser_valid !== 1'b0) begin
      bad++; $display("FAIL lsb_done got done=%b valid=%b exp done=1 valid=0", b_done, b_ser_valid);
    end
    b_shift_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_word();
    b_in_data = 8'h81; b_in_valid = 1'b1; b_shift_en = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (b_ser_valid !== 1'b1 || b_bit_idx !== 3'd4) begin
      bad++; $display("FAIL rst_mid_pre got valid=%b idx=%0d exp valid=1 idx=4", b_ser_valid, b_bit_idx);
    end
    b_rstn = 1'b0;
    #1;
    total++; if (b_ser_valid !== 1'b0 || b_in_ready !== 1'b1 || b_done !== 1'b0 ||
                 b_ser_out !== 1'b0 || b_bit_idx !== 3'd0) begin
      bad++; $display("FAIL rst_mid_async got valid=%b ready=%b done=%b out=%b idx=%0d exp 0 1 0 0 0",
                      b_ser_valid, b_in_ready, b_done, b_ser_out, b_bit_idx);
    end
    @(negedge clk);
    b_rstn = 1'b1; b_shift_en = 1'b0;
    @(negedge clk);
    total++; if (b_ser_valid !== 1'b0 || b_done !== 1'b0 || b_in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_after got valid=%b done=%b ready=%b exp 0 0 1", b_ser_valid, b_done, b_in_ready);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_msb_drain();
    test_stall();
    test_back_to_back();
    test_abort();
    test_lsb_first();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_out_reg.md
Name: shift_out_reg

Overview:
- Parallel-in / serial-out unload register. It is the reader-side counterpart to the enable-loaded storage flops.
- Captures a WIDTH-bit word through a valid/ready load handshake, then presents it one bit at a time to a serial consumer.
- The consumer advances the register with a shift strobe.
- Used by the debug/scan path and the serial TX datapath to drain processor registers onto a 1-bit link.

Parameters:
- WIDTH, 16, word width in bits; legal range 2..32.
- LSB_FIRST, 0, 0 = MSB shifted out first, 1 = LSB shifted out first.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  parallel word to unload.
- in_valid  input  1  producer offers in_data this cycle.
- in_ready  output  1  block can accept a word this cycle (combinational from state/count/shift_en).
- shift_en  input  1  consumer has taken the current ser_out bit; advance.
- abort  input  1  synchronous cancel of the current word.
- ser_out  output  1  current serial bit (registered data, valid when ser_valid=1).
- ser_valid  output  1  a bit is being presented (state SHIFT).
- bit_idx  output  $clog2(WIDTH)  bits remaining minus one (counts down WIDTH-1..0).
- done  output  1  one-cycle pulse after the final bit of a word is consumed.

Behaviour:
- Async reset (rstn=0):
  - State IDLE; shift register = 0; count = 0; done = 0.
  - Outputs: ser_out=0, ser_valid=0, in_ready=1, bit_idx=0.
- States are IDLE and SHIFT. No other states.
- IDLE:
  - in_ready=1, ser_valid=0.
  - On in_valid=1: load in_data into the shift register, set count=WIDTH-1, go to SHIFT next cycle.
  - shift_en is ignored in IDLE.
- SHIFT:
  - ser_valid=1.
  - ser_out is shreg[WIDTH-1] (LSB_FIRST=0) or shreg[0] (LSB_FIRST=1).
  - bit_idx=count.
- SHIFT with shift_en=1 and count>0:
  - Shift toward the output end by one.
  - Fill the vacated bit with 0.
  - Decrement count. Remain in SHIFT.
- SHIFT with shift_en=1 and count==0 (last bit consumed):
  - done=1 on the next cycle, for exactly one cycle.
  - If in_valid=1 the same cycle: in_ready=1, load the new word, count=WIDTH-1, stay in SHIFT. This is a back-to-back reload with no bubble, and done still pulses.
  - Otherwise go to IDLE.
- SHIFT with shift_en=0:
  - Hold all state.
  - ser_out/bit_idx stable indefinitely; consumer may stall any number of cycles.
- in_ready:
  - Equals 1 in IDLE, or in SHIFT when count==0 and shift_en=1.
  - 0 otherwise; in_valid while in_ready=0 has no effect.
- abort=1:
  - Highest priority.
  - Next cycle: state IDLE, shift register cleared, count=0, done=0.
  - Overrides a coincident load or last-shift in the same cycle; no done pulse is produced.
- Latency:
  - Load accepted at cycle N; first bit valid at N+1.
  - With shift_en held high, word fully drained at N+WIDTH; done asserted at N+WIDTH+1.
- Reset asserted mid-word: immediate return to reset values, no done pulse. On deassertion the block is in IDLE.
- count and bit_idx never wrap below 0; a shift at count==0 always ends the word.

Test Plan:
- Reset then idle:
  - Stimulus: rstn low 3 cycles, release.
  - Response: in_ready=1, ser_valid=0, ser_out=0, done=0.
- MSB-first drain (WIDTH=16, LSB_FIRST=0):
  - Stimulus: load 0xA5C3, shift_en held 1.
  - Response: ser_out sequence 1010 0101 1100 0011; bit_idx 15..0; done pulses 1 cycle at load+17.
- Stall:
  - Stimulus: load 0x8001, shift_en=0 for 5 cycles after 1st bit.
  - Response: ser_out=1, bit_idx=15 held for 5 cycles, then sequence resumes correctly.
- Back-to-back reload:
  - Stimulus: in_valid=1 with 0x00FF on the last-bit shift of 0xFFFF.
  - Response: in_ready=1 that cycle; next cycle ser_valid=1, bit_idx=15, ser_out=0; done pulses once.
- Abort and ignored load:
  - Stimulus: abort after 4 bits of 0x1234.
  - Response: next cycle ser_valid=0, in_ready=1, no done pulse.
  - Stimulus: in_valid during mid-word with in_ready=0.
  - Response: word unchanged.
- LSB-first (WIDTH=8, LSB_FIRST=1):
  - Stimulus: load 0x01.
  - Response: ser_out 1,0,0,0,0,0,0,0; done after the 8th shift.
  - Stimulus: rstn pulse mid-word.
  - Response: reset values, no done.
